// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - widths, FSM states and buffer entry layout for the fetch stage
package inst_fetch_unit_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  typedef enum logic {
    IF_RUN   = 1'b0,
    IF_FLUSH = 1'b1
  } if_state_e;

  typedef struct packed {
    logic                  fault;
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// rtl/inst_fetch_unit_fetch_fifo.sv - DEPTH-entry FIFO with occupancy count and synchronous clear
module inst_fetch_unit_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch stage: issues word fetches, buffers {inst, pc, fault}, flushes on redirect
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fetchPc,
  input  logic                  redirect,
  output logic                  pcAdvance,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemGnt,
  input  logic                  imemRvalid,
  input  logic [INST_WIDTH-1:0] imemRdata,
  output logic                  instValid,
  output logic [INST_WIDTH-1:0] instData,
  output logic [ADDR_WIDTH-1:0] instPc,
  input  logic                  instReady,
  output logic                  instFault
);

  localparam int CW = $clog2(DEPTH + 1);

  if_state_e              r_state;
  logic [CW-1:0]          r_discard;
  logic [CW-1:0]          w_occ;
  logic [CW-1:0]          w_outs;
  logic [CW:0]            w_inflight;
  logic [CW:0]            w_remaining;
  logic                   w_pop;
  logic                   w_credit;
  logic                   w_aligned;
  logic                   w_run;
  logic                   w_accept;
  logic                   w_resp;
  logic                   w_fault_push;
  logic [ADDR_WIDTH-1:0]  w_pend_pc;
  logic [ENTRY_WIDTH-1:0] w_head_bits;
  fetch_entry_t           w_head;
  fetch_entry_t           w_push_entry;

  assign w_run     = (r_state == IF_RUN) && !redirect;
  assign w_aligned = (fetchPc[1:0] == 2'b00);
  assign w_pop     = instValid && instReady && !redirect;

  // This cycle's pop frees a slot, so a drained buffer refills at one instruction per cycle.
  assign w_credit = ({1'b0, w_occ} + {1'b0, w_outs} - {{CW{1'b0}}, w_pop}) < (CW+1)'(DEPTH);

  assign imemReq      = reset && w_run && w_credit && w_aligned;
  assign imemAddr     = word_align(fetchPc);
  assign w_accept     = imemReq && imemGnt;
  assign pcAdvance    = w_accept;
  assign w_resp       = imemRvalid && w_run && (w_outs != '0);
  assign w_fault_push = w_run && w_credit && !w_aligned && (w_occ == '0) && (w_outs == '0);

  always_comb begin
    w_push_entry = '0;
    if (w_resp) begin
      w_push_entry.pc   = w_pend_pc;
      w_push_entry.inst = imemRdata;
    end else begin
      w_push_entry.fault = 1'b1;
      w_push_entry.pc    = fetchPc;
    end
  end

  inst_fetch_unit_fetch_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_pending (
    .clk     (clk),
    .reset   (reset),
    .i_clear (redirect),
    .i_push  (w_accept),
    .i_pop   (w_resp),
    .i_data  (fetchPc),
    .o_data  (w_pend_pc),
    .o_count (w_outs)
  );

  inst_fetch_unit_fetch_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (redirect),
    .i_push  (w_resp || w_fault_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_data  (w_head_bits),
    .o_count (w_occ)
  );

  // Only one of outs/discard is ever non-zero, so their sum is the count of responses still owed.
  assign w_inflight  = {1'b0, w_outs} + {1'b0, r_discard};
  assign w_remaining = w_inflight - {{CW{1'b0}}, (imemRvalid && (w_inflight != '0))};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IF_RUN;
      r_discard <= '0;
    end else if (redirect) begin
      r_discard <= w_remaining[CW-1:0];
      r_state   <= (w_remaining != '0) ? IF_FLUSH : IF_RUN;
    end else if ((r_state == IF_FLUSH) && imemRvalid && (r_discard != '0)) begin
      r_discard <= r_discard - 1'b1;
      if (r_discard == CW'(1)) r_state <= IF_RUN;
    end
  end

  assign instValid = (w_occ != '0);
  assign w_head    = instValid ? fetch_entry_t'(w_head_bits) : '0;
  assign instData  = w_head.inst;
  assign instPc    = w_head.pc;
  assign instFault = w_head.fault;

endmodule
